// File: rtl/fb_display_reader.sv
// Display-side frame-buffer reader: VGA-style timing, sequential read addresses, sync/DE aligned
// to returned pixel data. Define FB_TEST_PATTERN_EN to add i_pattern and an 8-bar colour source.
module fb_display_reader #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_en,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  input  logic [DATA_WIDTH-1:0] i_rdata,
`ifdef FB_TEST_PATTERN_EN
  input  logic                  i_pattern,
`endif
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_rgb,
  output logic                  o_frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned P        = RD_LATENCY + 1;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e                state_q, state_d;
  logic [1:0]            rst_sync_q;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [VW-1:0]         vcnt_q, vcnt_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [P-1:0]          act_pipe, hs_pipe, vs_pipe, fs_pipe;
  logic [DATA_WIDTH-1:0] pix;
  logic                  running, line_end, frame_end;
  logic                  s0_act, s0_hs, s0_vs, s0_first;

  // Deassertion is synchronised so the FSM never starts on a metastable release.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign running   = (state_q != StIdle);
  assign line_end  = (32'(hcnt_q) == H_TOTAL - 1);
  assign frame_end = line_end && (32'(vcnt_q) == V_TOTAL - 1);
  assign s0_act    = running && (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
  assign s0_hs     = running && (32'(hcnt_q) >= HS_START) && (32'(hcnt_q) < HS_END);
  assign s0_vs     = running && (32'(vcnt_q) >= VS_START) && (32'(vcnt_q) < VS_END);
  assign s0_first  = s0_act && (hcnt_q == '0) && (vcnt_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rst_sync_q[1] && i_en) state_d = StRun;
      StRun:   if (!i_en) state_d = frame_end ? StIdle : StStop;
      StStop:  if (frame_end) state_d = i_en ? StRun : StIdle;
      default: state_d = StIdle;
    endcase

    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!running) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (line_end) begin
      hcnt_d = '0;
      vcnt_d = frame_end ? '0 : vcnt_q + VW'(1);
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end

    // Address holds through blanking and is re-zeroed at the frame boundary.
    raddr_d = raddr_q;
    if (!running)       raddr_d = '0;
    else if (s0_act)    raddr_d = s0_first ? '0 : raddr_q + ADDR_WIDTH'(1);
    else if (frame_end) raddr_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= StIdle;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      raddr_q  <= '0;
      act_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      fs_pipe  <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      raddr_q  <= raddr_d;
      act_pipe <= {act_pipe[P-2:0], s0_act};
      hs_pipe  <= {hs_pipe[P-2:0], s0_hs};
      vs_pipe  <= {vs_pipe[P-2:0], s0_vs};
      fs_pipe  <= {fs_pipe[P-2:0], s0_first};
    end
  end

  assign o_raddr = raddr_q;

`ifdef FB_TEST_PATTERN_EN
  logic       pattern_q;
  logic [2:0] s0_bar;
  logic [2:0] bar_pipe [P];

  function automatic logic [11:0] bar_colour(input logic [2:0] bar);
    logic [11:0] c;
    case (bar)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  // Bar index by threshold comparison avoids a divider on hcnt.
  always_comb begin
    s0_bar = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (32'(hcnt_q) >= k * (H_ACTIVE / 8)) s0_bar = s0_bar + 3'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pattern_q <= 1'b0;
      for (int unsigned i = 0; i < P; i++) bar_pipe[i] <= 3'd0;
    end else begin
      if (s0_first) pattern_q <= i_pattern;
      bar_pipe[0] <= s0_bar;
      for (int unsigned i = 1; i < P; i++) bar_pipe[i] <= bar_pipe[i-1];
    end
  end

  always_comb begin
    pix = i_rdata;
    if (pattern_q) pix = DATA_WIDTH'(bar_colour(bar_pipe[P-1]));
  end
`else
  always_comb begin
    pix = i_rdata;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_de          <= 1'b0;
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_rgb         <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_de          <= act_pipe[P-1];
      o_hsync       <= hs_pipe[P-1] ? SYNC_POL : ~SYNC_POL;
      o_vsync       <= vs_pipe[P-1] ? SYNC_POL : ~SYNC_POL;
      o_rgb         <= act_pipe[P-1] ? pix : '0;
      o_frame_start <= fs_pipe[P-1];
    end
  end

endmodule

// File: tb/tb_fb_display_reader.sv
// Bench for fb_display_reader: two instances (read latency 1 and 3) on a shrunken raster,
// checked every cycle against a position/history model of the display timing.
module tb_fb_display_reader;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int AW = 19;
  localparam int DW = 12;
`ifdef FB_TEST_PATTERN_EN
  localparam bit HasPat = 1'b1;
`else
  localparam bit HasPat = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic pattern = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] raddr1, raddr3;
  logic [DW-1:0] rdata1, rdata3, rgb1, rgb3;
  logic          hs1, vs1, de1, fs1, hs3, vs3, de3, fs3;

  fb_display_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0), .RD_LATENCY(1)
  ) u_dut_l1 (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .o_raddr(raddr1), .i_rdata(rdata1),
`ifdef FB_TEST_PATTERN_EN
    .i_pattern(pattern),
`endif
    .o_hsync(hs1), .o_vsync(vs1), .o_de(de1), .o_rgb(rgb1), .o_frame_start(fs1)
  );

  fb_display_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0), .RD_LATENCY(3)
  ) u_dut_l3 (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .o_raddr(raddr3), .i_rdata(rdata3),
`ifdef FB_TEST_PATTERN_EN
    .i_pattern(pattern),
`endif
    .o_hsync(hs3), .o_vsync(vs3), .o_de(de3), .o_rgb(rgb3), .o_frame_start(fs3)
  );

  // Frame-buffer models: data = address[11:0], returned after 1 or 3 cycles.
  logic [11:0] bram1_q;
  logic [11:0] bram3_q [3];
  always_ff @(posedge clk) begin
    bram1_q    <= raddr1[11:0];
    bram3_q[0] <= raddr3[11:0];
    bram3_q[1] <= bram3_q[0];
    bram3_q[2] <= bram3_q[1];
  end
  assign rdata1 = bram1_q;
  assign rdata3 = bram3_q[2];

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [2:0]  bar;
    logic [11:0] pix;
  } entry_t;

  // hist[k] describes the raster position k cycles ago.
  entry_t        hist [6];
  bit            m_run, m_pat;
  int            m_h, m_v, m_sync;
  logic [AW-1:0] m_raddr;
  int            n_pass, n_checks, de_cnt, fs_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic entry_t make_entry(input bit run, input int h, input int v);
    entry_t e;
    e.act = run && h < HA && v < VA;
    e.hs  = run && h >= HA + HFP && h < HA + HFP + HSW;
    e.vs  = run && v >= VA + VFP && v < VA + VFP + VSW;
    e.fs  = e.act && h == 0 && v == 0;
    e.bar = 3'(h / (HA / 8));
    e.pix = 12'(v * HA + h);
    return e;
  endfunction

  function automatic logic [11:0] bar_colour(input logic [2:0] b);
    logic [11:0] tbl [8];
    tbl = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return tbl[b];
  endfunction

  function automatic logic [63:0] expect_out(input entry_t e);
    logic [11:0] rgb;
    rgb = 12'h000;
    if (e.act) rgb = m_pat ? bar_colour(e.bar) : e.pix;
    return {29'd0, e.act, ~e.hs, ~e.vs, e.fs, m_raddr, rgb};
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_pat = 1'b0; m_h = 0; m_v = 0; m_sync = 0; m_raddr = '0;
    for (int i = 0; i < 6; i++) hist[i] = make_entry(1'b0, 0, 0);
  endtask

  task automatic model_step();
    bit old_act, fend;
    old_act = m_run && m_h < HA && m_v < VA;
    fend    = m_h == HT - 1 && m_v == VT - 1;
    if (!m_run)       m_raddr = '0;
    else if (old_act) m_raddr = AW'(m_v * HA + m_h);
    else if (fend)    m_raddr = '0;
    if (m_run && m_h == 0 && m_v == 0) m_pat = HasPat && pattern;
    if (!m_run) begin
      if (m_sync >= 2 && en) m_run = 1'b1;
      m_h = 0; m_v = 0;
    end else if (fend) begin
      m_run = en; m_h = 0; m_v = 0;
    end else if (m_h == HT - 1) begin
      m_h = 0; m_v++;
    end else begin
      m_h++;
    end
    if (m_sync < 2) m_sync++;
    for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = make_entry(m_run, m_h, m_v);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstn) model_reset();
    else model_step();
    @(negedge clk);
    check("out_lat1", {29'd0, de1, hs1, vs1, fs1, raddr1, rgb1}, expect_out(hist[3]));
    check("out_lat3", {29'd0, de3, hs3, vs3, fs3, raddr3, rgb3}, expect_out(hist[5]));
    if (de1) de_cnt++;
    if (fs1) fs_cnt++;
  endtask

  task automatic wait_pos(input int v, input int h, input int limit);
    int n;
    n = 0;
    while (!(m_v == v && m_h == h) && n < limit) begin
      tick();
      n++;
    end
    if (!(m_v == v && m_h == h)) check("wait_pos_timeout", 64'(0), 64'(1));
  endtask

  // Asynchronous reset taken at a negedge; outputs must drop before the next clock edge.
  task automatic pulse_reset();
    rstn = 1'b0;
    #1;
    check("rst_lat1", {29'd0, de1, hs1, vs1, fs1, raddr1, rgb1}, {29'd0, 4'b0110, 31'd0});
    check("rst_lat3", {29'd0, de3, hs3, vs3, fs3, raddr3, rgb3}, {29'd0, 4'b0110, 31'd0});
    model_reset();
    repeat (3) tick();
    rstn = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_checks = 0; de_cnt = 0; fs_cnt = 0;
    model_reset();
    rstn = 1'b0; en = 1'b1; pattern = 1'b0;
    repeat (4) tick();

    // Start-up and three full frames: frame-start and DE totals.
    rstn = 1'b1; de_cnt = 0; fs_cnt = 0;
    repeat (3 * HT * VT - HT) tick();
    check("frame_starts", 64'(fs_cnt), 64'(3));
    check("de_cycles", 64'(de_cnt), 64'(3 * HA * VA));

    // Drop enable mid-frame, wiggle it during the drain, then expect idle.
    wait_pos(2, 5, 2 * HT * VT);
    en = 1'b0;
    tick();
    for (int n = 0; n < HT * VT && m_v != VT - 1; n++) begin
      en = 1'($urandom_range(0, 1));
      tick();
    end
    en = 1'b0;
    repeat (HT + 10) tick();
    de_cnt = 0;
    repeat (50) tick();
    check("idle_de", 64'(de_cnt), 64'(0));
    check("idle_raddr", 64'(raddr1), 64'(0));

    // Reset mid-line, then restart (with the pattern requested when it exists).
    en = 1'b1;
    wait_pos(3, 7, 2 * HT * VT + 20);
    pulse_reset();
    pattern = 1'b1; fs_cnt = 0;
    repeat (2 * HT * VT) tick();
    check("restart_frames", 64'(fs_cnt), 64'(2));

    // Random segments of enable, pattern and occasional reset.
    for (int seg = 0; seg < 14; seg++) begin
      en = ($urandom_range(0, 3) != 0);
      pattern = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) pulse_reset();
      repeat ($urandom_range(20, 400)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks, expected finish",
             n_checks);
    $fatal(1);
  end

endmodule
